// File: rtl/bp_pkg.sv
// Shared types and saturating-counter helpers for the branch predictor
// (the counter table and the branch target buffer).
package bp_pkg;

   typedef logic [1:0] ctr_t;

   localparam ctr_t CTR_SNT = 2'b00;
   localparam ctr_t CTR_WNT = 2'b01;
   localparam ctr_t CTR_WT  = 2'b10;
   localparam ctr_t CTR_ST  = 2'b11;

   function automatic ctr_t ctr_inc(input ctr_t c);
      return (c == CTR_ST) ? CTR_ST : ctr_t'(c + 2'b01);
   endfunction

   function automatic ctr_t ctr_dec(input ctr_t c);
      return (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'b01);
   endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side prediction and EX-side training signals of the branch predictor.
// The master side is the pipeline and the slave side is the predictor.
interface branch_predictor_if #(
   parameter int XLEN     = 32,
   parameter int BHR_BITS = 5
);

   logic [XLEN-1:0]     if_pc;
   logic                pred_taken;
   logic [XLEN-1:0]     pred_target;
   logic [XLEN-1:0]     pred_next_pc;
   logic [BHR_BITS-1:0] pred_bhr;

   logic                upd_valid;
   logic [XLEN-1:0]     upd_pc;
   logic                upd_is_cond;
   logic                upd_taken;
   logic [XLEN-1:0]     upd_target;
   logic [BHR_BITS-1:0] upd_bhr;

   modport master (
      output if_pc, upd_valid, upd_pc, upd_is_cond, upd_taken, upd_target, upd_bhr,
      input  pred_taken, pred_target, pred_next_pc, pred_bhr
   );

   modport slave (
      input  if_pc, upd_valid, upd_pc, upd_is_cond, upd_taken, upd_target, upd_bhr,
      output pred_taken, pred_target, pred_next_pc, pred_bhr
   );

endinterface

// File: rtl/bp_btb.sv
// Tagged branch target buffer: one combinational read port and one
// synchronous write port. Reset clears only the valid bits.
module bp_btb #(
   parameter int XLEN = 32,
   parameter int IDX  = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [IDX-1:0]        i_rdIdx,
   input  logic [XLEN-IDX-3:0]   i_rdTag,
   output logic                  o_hit,
   output logic [XLEN-1:0]       o_target,
   input  logic                  i_wrEn,
   input  logic [IDX-1:0]        i_wrIdx,
   input  logic [XLEN-IDX-3:0]   i_wrTag,
   input  logic [XLEN-1:0]       i_wrTarget
);

   localparam int ENTRIES = 1 << IDX;
   localparam int TAGW    = XLEN - IDX - 2;

   logic [ENTRIES-1:0] r_valid;
   logic [TAGW-1:0]    r_tag    [ENTRIES];
   logic [XLEN-1:0]    r_target [ENTRIES];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= '0;
      end else if (i_wrEn) begin
         r_valid[i_wrIdx] <= 1'b1;
      end
   end

   // Tag and target need no reset; a cleared valid bit masks them.
   always_ff @(posedge clk) begin
      if (i_wrEn && !reset) begin
         r_tag[i_wrIdx]    <= i_wrTag;
         r_target[i_wrIdx] <= i_wrTarget;
      end
   end

   assign o_hit    = r_valid[i_rdIdx] && (r_tag[i_rdIdx] == i_rdTag);
   assign o_target = r_target[i_rdIdx];

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: tagged BTB plus 2-bit counter table.
// Define BP_GSHARE_EN to XOR a global history register into the table index.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int   XLEN     = 32,
   parameter int   ENTRIES  = 32,
   parameter int   BHR_BITS = 5,
   parameter ctr_t CTR_INIT = 2'b01
) (
   input logic               clk,
   input logic               reset,
   branch_predictor_if.slave bus
);

   localparam int IDX  = $clog2(ENTRIES);
   localparam int TAGW = XLEN - IDX - 2;

   logic [IDX-1:0]  w_ifIdx;
   logic [TAGW-1:0] w_ifTag;
   logic [IDX-1:0]  w_updIdx;
   logic [TAGW-1:0] w_updTag;
   logic [IDX-1:0]  w_phtRdIdx;
   logic [IDX-1:0]  w_phtWrIdx;
   logic            w_hit;
   logic [XLEN-1:0] w_btbTarget;
   logic [XLEN-1:0] w_pcPlus4;
   logic            w_unusedPcBits;
   ctr_t            w_phtRd;
   ctr_t            r_pht [ENTRIES];

   assign w_ifIdx        = bus.if_pc[IDX+1:2];
   assign w_ifTag        = bus.if_pc[XLEN-1:IDX+2];
   assign w_updIdx       = bus.upd_pc[IDX+1:2];
   assign w_updTag       = bus.upd_pc[XLEN-1:IDX+2];
   assign w_unusedPcBits = ^{bus.if_pc[1:0], bus.upd_pc[1:0]};

`ifdef BP_GSHARE_EN
   logic [BHR_BITS-1:0] r_bhr;

   // History is trained only by resolved conditional branches.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bhr <= '0;
      end else if (bus.upd_valid && bus.upd_is_cond) begin
         r_bhr <= BHR_BITS'({r_bhr, bus.upd_taken});
      end
   end

   assign w_phtRdIdx   = w_ifIdx  ^ IDX'(r_bhr);
   assign w_phtWrIdx   = w_updIdx ^ IDX'(bus.upd_bhr);
   assign bus.pred_bhr = r_bhr;
`else
   logic w_unusedBhr;

   assign w_unusedBhr  = ^bus.upd_bhr;
   assign w_phtRdIdx   = w_ifIdx;
   assign w_phtWrIdx   = w_updIdx;
   assign bus.pred_bhr = '0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_pht[i] <= CTR_INIT;
         end
      end else if (bus.upd_valid) begin
         if (bus.upd_is_cond) begin
            r_pht[w_phtWrIdx] <= bus.upd_taken ? ctr_inc(r_pht[w_phtWrIdx])
                                               : ctr_dec(r_pht[w_phtWrIdx]);
         end else begin
            r_pht[w_phtWrIdx] <= CTR_ST;
         end
      end
   end

   // Only taken outcomes allocate; not-taken never touches the BTB.
   bp_btb #(
      .XLEN (XLEN),
      .IDX  (IDX)
   ) u_btb (
      .clk        (clk),
      .reset      (reset),
      .i_rdIdx    (w_ifIdx),
      .i_rdTag    (w_ifTag),
      .o_hit      (w_hit),
      .o_target   (w_btbTarget),
      .i_wrEn     (bus.upd_valid && bus.upd_taken),
      .i_wrIdx    (w_updIdx),
      .i_wrTag    (w_updTag),
      .i_wrTarget (bus.upd_target)
   );

   assign w_phtRd          = r_pht[w_phtRdIdx];
   assign w_pcPlus4        = bus.if_pc + XLEN'(4);
   assign bus.pred_taken   = w_hit && w_phtRd[1];
   assign bus.pred_target  = w_hit ? w_btbTarget : w_pcPlus4;
   assign bus.pred_next_pc = bus.pred_taken ? bus.pred_target : w_pcPlus4;

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the 5-stage RV32I pipeline: replaces the fixed `next_pc = current_pc + 4` fetch path with a tagged BTB plus 2-bit saturating-counter pattern table. Sits beside the PC register in IF and supplies the predicted next PC each cycle. Trains from resolved control-flow outcomes returned by EX. Optionally uses gshare indexing with a global history register.

## Interface
Parameters:
- `XLEN`, 32, address/data width.
- `ENTRIES`, 32, BTB and PHT depth.
  - Power of two, ≥ 4.
  - `IDX = log2(ENTRIES)`.
- `BHR_BITS`, 5, global history length.
  - 1 ≤ `BHR_BITS` ≤ `IDX`.
  - Only meaningful with `BP_GSHARE_EN`.
- `CTR_INIT`, 2'b01, counter value after reset (weakly not-taken).

Ports:
- `clk`  input  1  clock. All state changes on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `if_pc`  input  XLEN  PC being fetched.
- `pred_taken`  output  1  predicted taken (BTB hit and counter MSB set).
- `pred_target`  output  XLEN  BTB target on hit, else `if_pc + 4`.
- `pred_next_pc`  output  XLEN  `pred_taken ? pred_target : if_pc + 4`.
- `pred_bhr`  output  BHR_BITS  history snapshot used for this prediction. The pipeline carries it to EX.
- `upd_valid`  input  1  resolved control-flow instruction this cycle.
- `upd_pc`  input  XLEN  PC of resolved instruction.
- `upd_is_cond`  input  1  1 = conditional branch, 0 = jal/jalr.
- `upd_taken`  input  1  actual outcome. Must be 1 when `upd_is_cond` = 0.
- `upd_target`  input  XLEN  actual target.
- `upd_bhr`  input  BHR_BITS  `pred_bhr` snapshot carried with the instruction.

## Operation
Address fields:
- BTB index = `pc[IDX+1:2]`.
- Tag = `pc[XLEN-1:IDX+2]`.

BTB entry contents: valid, tag, target.
- Hit = valid && tag match.

PHT: `ENTRIES` 2-bit counters.
- Read index = `pc[IDX+1:2] ^ {0, bhr}` (gshare), or `pc[IDX+1:2]` (bimodal).

Prediction:
- Purely combinational from current state.
- `pred_taken = hit && pht[idx][1]`.

Update, when `upd_valid && !reset`:
- BTB: if `upd_taken`, write entry at the `upd_pc` index with valid = 1, the `upd_pc` tag and `upd_target`. Not-taken outcomes never allocate or invalidate.
- PHT, conditional branch (index built from `upd_pc` and `upd_bhr`):
  - taken → saturating increment;
  - not-taken → saturating decrement;
  - saturates at 2'b00 and 2'b11.
- PHT, jal/jalr: counter forced to 2'b11.
- BHR (gshare only): `bhr <= {bhr[BHR_BITS-2:0], upd_taken}`, on conditional updates only.
  - BHR is non-speculative; no recovery is needed.

Reset:
- All valid bits cleared.
- All counters set to `CTR_INIT`.
- BHR cleared to 0.
- An `upd_valid` asserted in a reset cycle is dropped.

Resulting outputs after reset:
- `pred_taken` = 0.
- `pred_target` = `pred_next_pc` = `if_pc + 4`.
- `pred_bhr` = 0.

No stall input is needed: the block holds no fetch-side state, so a held `if_pc` just re-reads the tables.

## Timing
- Prediction latency: 0 cycles (combinational `if_pc` → `pred_*`).
- Update latency: written on the edge where `upd_valid` = 1; visible to predictions from the next cycle.
- Same-cycle update and predict at the same index: the prediction uses pre-update contents. There is no bypass.
- Two entries aliasing one index: the later taken update overwrites the tag/target. The PHT counter is shared and not tag-checked.
- `pc + 4` wraps modulo 2^XLEN.

## Configuration
- `BP_GSHARE_EN` defined:
  - BHR register instantiated.
  - PHT index is XORed with history as above.
  - `pred_bhr` reflects the BHR.
- `BP_GSHARE_EN` undefined:
  - No BHR flops.
  - PHT indexed by PC bits only.
  - `pred_bhr` tied to 0 and `upd_bhr` ignored.
  - Port list unchanged.

## Structure
- Package `bp_pkg`:
  - `ctr_t` (2-bit) typedef.
  - Constants `CTR_SNT`/`CTR_WNT`/`CTR_WT`/`CTR_ST`.
  - Functions `ctr_inc`/`ctr_dec` (saturating).
- Sub-module `bp_btb`:
  - Valid/tag/target arrays, one combinational read port, one synchronous write port.
  - PHT and BHR stay in the top module.

## Test plan
- Reset, then `if_pc` = 0x100 → `pred_taken` = 0, `pred_next_pc` = 0x104.
- Single taken conditional update (`upd_pc` 0x100, target 0x80, bimodal) → next cycle `if_pc` 0x100 gives `pred_taken` = 1, `pred_next_pc` = 0x80 (counter 01→10).
- Saturation, bimodal, same 0x100 branch:
  - 3 further taken updates → counter 11;
  - then 1 not-taken → still taken (10);
  - a 2nd not-taken → `pred_next_pc` = 0x104.
- Aliasing, `ENTRIES` = 32: taken at 0x100 → 0x80, then query 0x180 (same index, different tag) → miss, `pred_next_pc` = 0x184. Then a taken update at 0x180 → 0x40 → query 0x100 now misses.
- jal update at 0x200 → 0x40 → next cycle `pred_next_pc` = 0x40. With `BP_GSHARE_EN`, BHR is unchanged (still 0).
- Same-cycle conflict: `upd_valid` (0x100 taken → 0x80) while `if_pc` = 0x100 on a cold table → that cycle `pred_next_pc` = 0x104, next cycle 0x80. With `BP_GSHARE_EN` and `reset` held, the update is dropped and BHR stays 0.
